linebuffer_3x3_ctrl: RTL and testbench
======================================

LINEBUFFER_3X3_CTRL -- requirements
Module: linebuffer_3x3_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel data width.
REQ-002 SHALL have parameter CW, default 8, meaning row/column counter width (holds 0..223).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, frame start request, sampled in IDLE only.
REQ-006 SHALL have port cfg_size, input, 3, line-length code: 0..5 = width 8, 14, 28, 56, 112, 224; 6 and 7 are invalid.
REQ-007 SHALL have port cfg_stride, input, 1, window stride: 0 = stride 1, 1 = stride 2.
REQ-008 SHALL have port in_valid, input, 1, upstream pixel valid.
REQ-009 SHALL have port in_data, input, DW, upstream pixel.
REQ-010 SHALL have port in_ready, output, 1, pixel accepted when in_valid and in_ready are both 1.
REQ-011 SHALL have port lb_sel, output, 3, tap select to the line buffer.
REQ-012 SHALL have port lb_data, output, DW, pixel stream to the line buffer.
REQ-013 SHALL have port win_valid, output, 1, the line-buffer 3x3 window holds a valid, stride-aligned window.
REQ-014 SHALL have port win_row and win_col, output, CW each, centre-minus-one coordinates of the current window.
REQ-015 SHALL have port win_last, output, 1, the current valid window is the last one of the frame.
REQ-016 SHALL have ports frame_done, output, 1, one-cycle end-of-frame pulse; and busy, output, 1.
REQ-017 SHALL have ports err, output, 1, sticky underrun flag; and cfg_err, output, 1, one-cycle invalid-config pulse.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN and ERR.
REQ-019 In IDLE with start=1 and cfg_size<=5, the block SHALL latch cfg_size into lb_sel, latch cfg_stride, clear row/col, and enter RUN next cycle.
REQ-020 In IDLE with start=1 and cfg_size>=6, the block SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-021 start SHALL be ignored in RUN, DRAIN and ERR.
REQ-022 in_ready SHALL be 1 only in RUN, and busy SHALL be 1 in RUN and DRAIN.
REQ-023 lb_data SHALL equal in_data when a pixel is accepted and 0 otherwise (combinational); lb_sel SHALL stay stable from RUN entry until the next start.
REQ-024 Each accepted pixel SHALL advance col; when col reaches W-1, col SHALL wrap to 0 and row SHALL increment; the frame is W x W pixels.
REQ-025 In RUN, a cycle with in_valid=0 SHALL be an underrun, because the line buffer shifts every clock: the block SHALL enter ERR and set err=1.
REQ-026 In ERR, err SHALL remain 1, in_ready SHALL be 0, and the block SHALL leave ERR only on rst.
REQ-027 The block SHALL register win_valid=1 in the cycle after accepting the pixel at (r,c) when r>=2, c>=2, and (for stride 2) (r-2) and (c-2) are both even; windows with c<2 straddle rows and SHALL be suppressed.
REQ-028 win_row/win_col SHALL register r-2 and c-2 with the same one-cycle latency as win_valid, and SHALL hold their value when win_valid=0.
REQ-029 win_last SHALL be asserted with win_valid on position (W-1,W-1) for stride 1 and on (W-2,W-2) for stride 2.
REQ-030 Acceptance of pixel (W-1,W-1) SHALL move RUN to DRAIN.
REQ-031 DRAIN SHALL last one cycle with frame_done=1 and then return to IDLE.
REQ-032 Window count per frame SHALL be (W-2)^2 for stride 1 and ((W-2)/2)^2 for stride 2.

Reset
REQ-033 rst SHALL force IDLE, regardless of state (including mid-frame RUN or ERR).
REQ-034 rst SHALL clear row, col, lb_sel, the stride latch, in_ready, win_valid, win_last, win_row, win_col, frame_done, busy, err and cfg_err to 0.
REQ-035 Stale line-buffer contents after reset SHALL need no flush; REQ-027 masking covers them.

Structure
REQ-036 The size-code-to-width table (8, 14, 28, 56, 112, 224) and the state encoding SHALL live in shared package linebuffer_pkg, for use by the line buffer and its controllers.
REQ-037 No sub-module is required; row/col counters and the FSM SHALL be inline.

Verification
REQ-038 Bench SHALL cover: cfg_size=0, stride 1, 64 contiguous pixels -> first win_valid one cycle after pixel index 18 with win_row=0/win_col=0; exactly 36 windows; win_last and frame_done in the cycle after pixel 63.
REQ-039 Bench SHALL cover: cfg_size=0, stride 2 -> 9 windows at (0,0),(0,2)..(4,4); win_last at win_row=4/win_col=4.
REQ-040 Bench SHALL cover: cfg_size=1, in_valid dropped at pixel 10 -> err=1 next cycle; in_ready=0 and no further windows until rst.
REQ-041 Bench SHALL cover: start with cfg_size=6 -> cfg_err one-cycle pulse; busy stays 0; lb_sel unchanged.
REQ-042 Bench SHALL cover: rst at pixel 30 of a W=8 frame -> all outputs 0 next cycle; a following full frame yields 36 correct windows.
REQ-043 Bench SHALL cover: start pulsed during RUN -> ignored; counters and lb_sel undisturbed.

Source files
------------

// File: rtl/linebuffer_pkg.sv
// Shared definitions for the 3x3 line buffer and its controllers:
// controller state encoding and the size-code to line-width table.
package linebuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } lb_state_e;

    localparam logic [2:0] SIZE_CODE_MAX = 3'd5;

    // Line width in pixels for a size code; invalid codes map to 0.
    function automatic logic [7:0] size_width(input logic [2:0] code);
        case (code)
            3'd0:    return 8'd8;
            3'd1:    return 8'd14;
            3'd2:    return 8'd28;
            3'd3:    return 8'd56;
            3'd4:    return 8'd112;
            3'd5:    return 8'd224;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/linebuffer_3x3_ctrl.sv
// Controller feeding a shift-every-clock 3x3 line buffer: tracks frame
// position, flags valid stride-aligned windows and traps input underruns.
module linebuffer_3x3_ctrl
    import linebuffer_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    cfg_size,
    input  logic          cfg_stride,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [2:0]    lb_sel,
    output logic [DW-1:0] lb_data,
    output logic          win_valid,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          win_last,
    output logic          frame_done,
    output logic          busy,
    output logic          err,
    output logic          cfg_err
);

    lb_state_e     state_r;
    logic [CW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic [2:0]    lb_sel_r;
    logic          stride2_r;
    logic          in_ready_r;
    logic          win_valid_r;
    logic          win_last_r;
    logic [CW-1:0] win_row_r;
    logic [CW-1:0] win_col_r;
    logic          frame_done_r;
    logic          busy_r;
    logic          err_r;
    logic          cfg_err_r;

    logic          accept_s;
    logic [CW-1:0] w_m1_s;
    logic [CW-1:0] w_m2_s;
    logic          win_hit_s;
    logic          last_win_s;

    // Window qualification for the pixel currently on the input.
    always_comb begin
        accept_s   = in_valid & in_ready_r;
        w_m1_s     = CW'(size_width(lb_sel_r)) - CW'(1'b1);
        w_m2_s     = CW'(size_width(lb_sel_r)) - CW'(2'd2);
        win_hit_s  = 1'b0;
        last_win_s = 1'b0;
        if ((row_r >= CW'(2'd2)) && (col_r >= CW'(2'd2))) begin
            // With stride 2 the anchor (r-2, c-2) must be even in both axes.
            win_hit_s = ~stride2_r | (~row_r[0] & ~col_r[0]);
        end else begin
            win_hit_s = 1'b0;
        end
        if (stride2_r) begin
            last_win_s = (row_r == w_m2_s) && (col_r == w_m2_s);
        end else begin
            last_win_s = (row_r == w_m1_s) && (col_r == w_m1_s);
        end
    end

    // Pixel stream to the line buffer is zeroed on non-accepting cycles.
    always_comb begin
        if (accept_s) begin
            lb_data = in_data;
        end else begin
            lb_data = {DW{1'b0}};
        end
    end

    // Control FSM with frame counters and registered window flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            row_r        <= {CW{1'b0}};
            col_r        <= {CW{1'b0}};
            lb_sel_r     <= 3'd0;
            stride2_r    <= 1'b0;
            in_ready_r   <= 1'b0;
            win_valid_r  <= 1'b0;
            win_last_r   <= 1'b0;
            win_row_r    <= {CW{1'b0}};
            win_col_r    <= {CW{1'b0}};
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            win_valid_r  <= 1'b0;
            win_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            cfg_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (cfg_size <= SIZE_CODE_MAX)) begin
                        lb_sel_r   <= cfg_size;
                        stride2_r  <= cfg_stride;
                        row_r      <= {CW{1'b0}};
                        col_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_RUN;
                    end else if (start) begin
                        cfg_err_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        win_valid_r <= win_hit_s;
                        if (win_hit_s) begin
                            win_row_r  <= row_r - CW'(2'd2);
                            win_col_r  <= col_r - CW'(2'd2);
                            win_last_r <= last_win_s;
                        end
                        if (col_r == w_m1_s) begin
                            col_r <= {CW{1'b0}};
                            if (row_r == w_m1_s) begin
                                in_ready_r   <= 1'b0;
                                frame_done_r <= 1'b1;
                                state_r      <= ST_DRAIN;
                            end else begin
                                row_r <= row_r + CW'(1'b1);
                            end
                        end else begin
                            col_r <= col_r + CW'(1'b1);
                        end
                    end else begin
                        // The line buffer shifts every clock, so a bubble corrupts it.
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        err_r      <= 1'b1;
                        state_r    <= ST_ERR;
                    end
                end
                ST_DRAIN: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    err_r      <= 1'b1;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
                default: begin
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign lb_sel     = lb_sel_r;
    assign win_valid  = win_valid_r;
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;
    assign win_last   = win_last_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;
    assign err        = err_r;
    assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// Directed bench for linebuffer_3x3_ctrl: a pixel-index model predicts every
// output each cycle, and per-frame literal expectations pin the model.
module tb_linebuffer_3x3_ctrl;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    cfg_size;
    logic          cfg_stride;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [2:0]    lb_sel;
    logic [DW-1:0] lb_data;
    logic          win_valid;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          win_last;
    logic          frame_done;
    logic          busy;
    logic          err;
    logic          cfg_err;

    always #5 clk = ~clk;

    linebuffer_3x3_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_size(cfg_size),
        .cfg_stride(cfg_stride), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .lb_sel(lb_sel), .lb_data(lb_data),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .win_last(win_last), .frame_done(frame_done), .busy(busy),
        .err(err), .cfg_err(cfg_err)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Model: mode 0 idle, 1 running, 2 draining, 3 error
    int   m_mode = 0;
    int   m_w = 0, m_k = 0, m_stride = 0, m_wins = 0, m_total = 0;
    logic e_in_ready = 1'b0, e_busy = 1'b0, e_err = 1'b0, e_cfg_err = 1'b0;
    logic e_wv = 1'b0, e_wl = 1'b0, e_fd = 1'b0;
    logic [2:0] e_sel = 3'd0;
    int   e_row = 0, e_col = 0;
    int   last_acc = -1;
    bit   chk_en = 1'b0;

    int dut_wcnt, first_idx, first_row, first_col, last_row, last_col, last_idx, cfg_err_cnt;
    bit saw_done_with_last;

    function automatic int width_of(input int code);
        case (code)
            0: return 8;
            1: return 14;
            2: return 28;
            3: return 56;
            4: return 112;
            5: return 224;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_stats();
        dut_wcnt = 0; first_idx = -1; first_row = -1; first_col = -1;
        last_row = -1; last_col = -1; last_idx = -1; cfg_err_cnt = 0;
        saw_done_with_last = 1'b0;
    endtask

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, e_in_ready);
            chk("busy", busy, e_busy);
            chk("err", err, e_err);
            chk("cfg_err", cfg_err, e_cfg_err);
            chk("win_valid", win_valid, e_wv);
            chk("win_last", win_last, e_wl);
            chk("frame_done", frame_done, e_fd);
            chk("lb_sel", lb_sel, e_sel);
            chk("win_row", win_row, e_row);
            chk("win_col", win_col, e_col);
            chk("lb_data", lb_data, (in_valid && e_in_ready) ? in_data : 8'd0);
            if (win_valid === 1'b1) begin
                dut_wcnt++;
                if (first_idx < 0) begin
                    first_idx = last_acc; first_row = win_row; first_col = win_col;
                end
                if (win_last === 1'b1) begin
                    last_idx = last_acc; last_row = win_row; last_col = win_col;
                    saw_done_with_last = (frame_done === 1'b1);
                end
            end
            if (cfg_err === 1'b1) cfg_err_cnt++;
        end
    end

    // One clock: wait for the edge, then update the model from the inputs it saw.
    task automatic cycle();
        int r, c;
        @(posedge clk);
        #1;
        e_wv = 1'b0; e_wl = 1'b0; e_fd = 1'b0; e_cfg_err = 1'b0; last_acc = -1;
        if (rst) begin
            m_mode = 0; e_in_ready = 1'b0; e_busy = 1'b0; e_err = 1'b0;
            e_sel = 3'd0; e_row = 0; e_col = 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    if (cfg_size <= 3'd5) begin
                        e_sel = cfg_size; m_w = width_of(int'(cfg_size));
                        m_stride = int'(cfg_stride); m_k = 0; m_wins = 0;
                        m_total = (m_stride == 0) ? (m_w - 2) * (m_w - 2)
                                                  : ((m_w - 2) / 2) * ((m_w - 2) / 2);
                        m_mode = 1; e_in_ready = 1'b1; e_busy = 1'b1;
                    end else begin
                        e_cfg_err = 1'b1;
                    end
                end
                1: if (in_valid) begin
                    r = m_k / m_w; c = m_k % m_w; last_acc = m_k; m_k++;
                    if (r >= 2 && c >= 2 &&
                        (m_stride == 0 || ((r - 2) % 2 == 0 && (c - 2) % 2 == 0))) begin
                        m_wins++; e_wv = 1'b1; e_row = r - 2; e_col = c - 2;
                        e_wl = (m_wins == m_total);
                    end
                    if (m_k == m_w * m_w) begin
                        m_mode = 2; e_in_ready = 1'b0; e_fd = 1'b1;
                    end
                end else begin
                    m_mode = 3; e_err = 1'b1; e_in_ready = 1'b0; e_busy = 1'b0;
                end
                2: begin
                    m_mode = 0; e_busy = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (n) cycle();
    endtask

    task automatic start_frame(input int size, input int stride);
        cfg_size = 3'(size); cfg_stride = 1'(stride); start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Present n pixels back to back; optional bubble, stray start, or reset.
    task automatic pixels(input int n, input int drop_at, input int start_at, input int rst_at);
        logic [2:0] keep_size;
        logic       keep_stride;
        keep_size = cfg_size; keep_stride = cfg_stride;
        for (int i = 0; i < n; i++) begin
            in_valid = (i != drop_at);
            in_data  = 8'(i * 7 + 3);
            start    = (i == start_at);
            if (i == start_at) begin
                cfg_size = 3'd3; cfg_stride = ~keep_stride;
            end else begin
                cfg_size = keep_size; cfg_stride = keep_stride;
            end
            rst = (i == rst_at);
            cycle();
        end
        in_valid = 1'b0; start = 1'b0; rst = 1'b0;
        cfg_size = keep_size; cfg_stride = keep_stride;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_size = 3'd0; cfg_stride = 1'b0;
        in_valid = 1'b0; in_data = 8'd0;
        reset_stats();
        cycle();
        chk_en = 1'b1;
        cycle();
        rst = 1'b0;
        idle(2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_err", err, 1'b0);

        // W=8 stride 1
        reset_stats();
        start_frame(0, 0);
        pixels(64, -1, -1, -1);
        idle(3);
        chk("A_first_idx", first_idx, 18);
        chk("A_first_row", first_row, 0);
        chk("A_first_col", first_col, 0);
        chk("A_windows", dut_wcnt, 36);
        chk("A_last_idx", last_idx, 63);
        chk("A_last_row", last_row, 5);
        chk("A_last_col", last_col, 5);
        chk("A_done_with_last", saw_done_with_last, 1'b1);

        // W=8 stride 2
        reset_stats();
        start_frame(0, 1);
        pixels(64, -1, -1, -1);
        idle(3);
        chk("B_windows", dut_wcnt, 9);
        chk("B_first_idx", first_idx, 18);
        chk("B_last_row", last_row, 4);
        chk("B_last_col", last_col, 4);
        chk("B_last_idx", last_idx, 54);

        // W=14 stride 1 with a stray start at pixel 50
        reset_stats();
        start_frame(1, 0);
        pixels(196, -1, 50, -1);
        idle(3);
        chk("E_windows", dut_wcnt, 144);
        chk("E_last_idx", last_idx, 195);
        chk("E_lb_sel", lb_sel, 3'd1);

        // Invalid size code
        reset_stats();
        cfg_size = 3'd6; start = 1'b1;
        cycle();
        start = 1'b0;
        idle(3);
        chk("G_cfg_err_pulses", cfg_err_cnt, 1);
        chk("G_busy", busy, 1'b0);
        chk("G_lb_sel", lb_sel, 3'd1);

        // Underrun at pixel 10 of W=14
        reset_stats();
        start_frame(1, 0);
        pixels(16, 10, 13, -1);
        idle(3);
        chk("D_err", err, 1'b1);
        chk("D_in_ready", in_ready, 1'b0);
        chk("D_windows", dut_wcnt, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(1);
        chk("D_err_after_rst", err, 1'b0);

        // Reset mid-frame, then a clean frame
        start_frame(0, 0);
        pixels(40, -1, -1, 30);
        idle(2);
        chk("F_busy_after_rst", busy, 1'b0);
        reset_stats();
        start_frame(0, 0);
        pixels(64, -1, -1, -1);
        idle(3);
        chk("F_windows", dut_wcnt, 36);
        chk("F_last_idx", last_idx, 63);
        chk("F_first_idx", first_idx, 18);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
